mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between the execute stage and the write-back stage of the 5-stage MIPS core. It holds one instruction, waits for the data-SRAM response of any load issued in execute, and buffers that response if write-back stalls. It aligns and sign/zero-extends load data, including LWL/LWR byte-merge write enables, and repacks everything into the 126-bit MEM→WB bus. It also discards stale SRAM responses that belong to instructions killed by an exception or ERET flush.

## Interface
Parameters: none. Widths come from `mycpu.h`:
- `ES_TO_MS_BUS_WD`, 166: execute→mem bus width.
- `MS_TO_WS_BUS_WD`, 126: mem→WB bus width.
- `STALL_BUS_WD`, 10: hazard-detect bus width.
- `FORWARD_BUS_WD`, 33: forwarding bus width.

Ports. One clock `clk`; `reset` is synchronous, active-high.
- `clk` in 1: core clock.
- `reset` in 1: synchronous active-high reset.
- `flush` in 1: exception/ERET flush from WB.
- `ws_allowin` in 1: WB can accept.
- `ms_allowin` out 1: this stage can accept.
- `es_to_ms_valid` in 1: execute offers an instruction.
- `es_to_ms_bus` in 166, packed MSB→LSB:
  - badvaddr 32, bd 1, exc 1, exc_type 8
  - eret_flush 1, cp0_wen 1, res_from_cp0 1, cp0_addr 8
  - gr_we 4, dest 5
  - load_op 7, one-hot {lb, lbu, lh, lhu, lw, lwl, lwr}
  - mem_req 1 (a data-SRAM read was issued in execute)
  - rt_value 32, alu_result 32, pc 32
- `ms_to_ws_valid` out 1: instruction valid toward WB.
- `ms_to_ws_bus` out 126, packed MSB→LSB:
  - badvaddr 32, bd 1, exc 1, exc_type 8
  - eret_flush 1, cp0_wen 1, res_from_cp0 1, cp0_addr 8
  - gr_we 4, dest 5
  - mem_alu_result 32, pc 32
- `data_sram_data_ok` in 1: in-order read response strobe.
- `data_sram_rdata` in 32: read data, valid with `data_ok`.
- `stall_ms_bus` out 10: {ms_valid && |gr_we, gr_we & {4{ms_valid}}, dest}.
- `forward_ms_bus` out 33: {ms_valid && ready_go, final_result}.
- `ms_exc_eret_bus` out 2: {ms_valid && exc, ms_valid && eret_flush}. Execute uses it to suppress store requests.

## Operation
- **need_resp**: mem_req && !exc.
- **ready_go**:
  - 1 if !need_resp.
  - Otherwise 1 when data_ok is high (and not being discarded) or buf_valid is set.
- **Response buffer** (buf_valid, buf_data):
  - Set when data_ok arrives for this stage's instruction while ms_valid && need_resp && !ws_allowin.
  - Cleared when the instruction leaves the stage, on flush, or on reset.
- **Load data source**: buf_valid ? buf_data : data_sram_rdata.
- **Byte/half select**: uses alu_result[1:0], little-endian.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- **lwl** at offset k (0..3):
  - Result bytes [3:3-k] = memory bytes [k:0].
  - gr_we: 1000, 1100, 1110, 1111.
- **lwr** at offset k:
  - Result bytes [3-k:0] = memory bytes [3:k].
  - gr_we: 1111, 0111, 0011, 0001.
  - Unwritten bytes carry rt_value.
- **gr_we**: non-load instructions pass gr_we through unchanged. If exc=1, gr_we is forced to 0000.
- **final_result**: the loaded value for loads, else alu_result. It feeds both the mem_alu_result field and `forward_ms_bus`.
- **Discard state machine**: states IDLE and DISCARD.
  - IDLE→DISCARD on flush while ms_valid && need_resp && !data_ok && !buf_valid.
  - DISCARD→IDLE on the next data_ok, which is consumed and never used as load data.
  - In DISCARD, data_ok does not count toward ready_go.

## Timing
- Reset values:
  - ms_valid=0, buf_valid=0, state IDLE.
  - ms_allowin=1, ms_to_ws_valid=0.
  - stall_ms_bus MSB=0, forward valid=0, ms_exc_eret_bus=00.
- Handshake:
  - ms_allowin = !ms_valid || (ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ready_go.
  - Input bus is registered when es_to_ms_valid && ms_allowin.
- Latency:
  - Non-load: 1 cycle.
  - Load: data_ok cycle is the earliest WB transfer, with no extra registering of the response.
- Flush: clears ms_valid next cycle. It overrides a simultaneous capture, and the incoming instruction is dropped.
- Flush in the same cycle as data_ok: response is consumed, no DISCARD.
- Reset mid-DISCARD: returns to IDLE; the external SRAM is reset together with the core.

## Structure
- `mycpu.h` holds the four bus widths and the load_op bit positions.
- One combinational sub-module, `mem_load_align`:
  - Inputs: load_op, addr[1:0], rdata, rt_value, gr_we_in.
  - Outputs: result, gr_we_out.
- All state (ms_valid, bus register, buffer, discard FSM) stays in `mem_stage`.

## Test plan
- ALU op, pc=0xBFC00010, alu_result=0x1234: transfers to WB next cycle with mem_alu_result=0x1234, gr_we=1111.
- lb at addr offset 2, rdata=0x00800000: result 0xFFFFFF80. The same with lbu gives 0x00000080.
- lwl offset 1, rdata=0xAABBCCDD, rt=0x11223344: result 0xCCDD3344, gr_we=1100. lwr offset 2, same inputs: result 0x1122AABB, gr_we=0011.
- data_ok arrives with ws_allowin=0 for 3 cycles: buf_valid set, data held. On release, the correct data transfers and buf_valid clears.
- flush while a load waits, data_ok 2 cycles later, then a new load whose data_ok carries 0x5A5A5A5A: first response dropped; the new load returns 0x5A5A5A5A.
- Load with exc=1 and mem_req=1: ready_go immediate, no wait for data_ok, gr_we=0000, ms_exc_eret_bus=10.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, bus layouts and state encoding for the memory-access stage.
package mem_stage_pkg;

  localparam int unsigned ES_TO_MS_BUS_WD = 166;
  localparam int unsigned MS_TO_WS_BUS_WD = 126;
  localparam int unsigned STALL_BUS_WD    = 10;
  localparam int unsigned FORWARD_BUS_WD  = 33;
  localparam int unsigned LOAD_OP_WD      = 7;

  // One-hot load_op bit positions: {lb, lbu, lh, lhu, lw, lwl, lwr}
  localparam int unsigned LD_LB  = 6;
  localparam int unsigned LD_LBU = 5;
  localparam int unsigned LD_LH  = 4;
  localparam int unsigned LD_LHU = 3;
  localparam int unsigned LD_LW  = 2;
  localparam int unsigned LD_LWL = 1;
  localparam int unsigned LD_LWR = 0;

  typedef struct packed {
    logic [31:0]           badvaddr;
    logic                  bd;
    logic                  exc;
    logic [7:0]            exc_type;
    logic                  eret_flush;
    logic                  cp0_wen;
    logic                  res_from_cp0;
    logic [7:0]            cp0_addr;
    logic [3:0]            gr_we;
    logic [4:0]            dest;
    logic [LOAD_OP_WD-1:0] load_op;
    logic                  mem_req;
    logic [31:0]           rt_value;
    logic [31:0]           alu_result;
    logic [31:0]           pc;
  } es_to_ms_t;

  typedef struct packed {
    logic [31:0] badvaddr;
    logic        bd;
    logic        exc;
    logic [7:0]  exc_type;
    logic        eret_flush;
    logic        cp0_wen;
    logic        res_from_cp0;
    logic [7:0]  cp0_addr;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] mem_alu_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_DISCARD = 1'b1
  } discard_state_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment, sign/zero extension and LWL/LWR byte merge.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [LOAD_OP_WD-1:0] load_op,
  input  logic [1:0]            addr,
  input  logic [31:0]           rdata,
  input  logic [31:0]           rt_value,
  input  logic [3:0]            gr_we_in,
  output logic [31:0]           result,
  output logic [3:0]            gr_we_out
);

  logic [4:0]  lwl_sh;
  logic [4:0]  lwr_sh;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] lwl_mask;
  logic [31:0] lwr_mask;
  logic [31:0] lwl_data;
  logic [31:0] lwr_data;

  // Select addressed byte/half and build the partial-word merges
  always_comb begin
    lwl_sh    = {~addr, 3'b000};
    lwr_sh    = {addr, 3'b000};
    byte_sel  = 8'(rdata >> lwr_sh);
    half_sel  = addr[1] ? rdata[31:16] : rdata[15:0];
    lwl_mask  = 32'hFFFF_FFFF << lwl_sh;
    lwr_mask  = 32'hFFFF_FFFF >> lwr_sh;
    lwl_data  = (rdata << lwl_sh) | (rt_value & ~lwl_mask);
    lwr_data  = (rdata >> lwr_sh) | (rt_value & ~lwr_mask);
    result    = rdata;
    gr_we_out = gr_we_in;
    if (load_op[LD_LB]) begin
      result = {{24{byte_sel[7]}}, byte_sel};
    end else if (load_op[LD_LBU]) begin
      result = {24'h0, byte_sel};
    end else if (load_op[LD_LH]) begin
      result = {{16{half_sel[15]}}, half_sel};
    end else if (load_op[LD_LHU]) begin
      result = {16'h0, half_sel};
    end else if (load_op[LD_LWL]) begin
      result    = lwl_data;
      gr_we_out = 4'(4'b1111 << ~addr);
    end else if (load_op[LD_LWR]) begin
      result    = lwr_data;
      gr_we_out = 4'(4'b1111 >> addr);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for/buffers SRAM load data, aligns it,
// and drops responses that belong to flushed instructions.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [STALL_BUS_WD-1:0]    stall_ms_bus,
  output logic [FORWARD_BUS_WD-1:0]  forward_ms_bus,
  output logic [1:0]                 ms_exc_eret_bus
);

  logic           ms_valid;
  es_to_ms_t      ms_r;
  logic           buf_valid;
  logic [31:0]    buf_data;
  discard_state_t state;

  logic           need_resp;
  logic           data_ok_use;
  logic           ready_go;
  logic           leave;
  logic [31:0]    load_data;
  logic [31:0]    align_result;
  logic [3:0]     align_we;
  logic [3:0]     gr_we_final;
  logic [31:0]    final_result;
  ms_to_ws_t      ws_bus;

  // A response arriving while discarding belongs to a killed instruction
  assign need_resp      = ms_r.mem_req && !ms_r.exc;
  assign data_ok_use    = data_sram_data_ok && (state == S_IDLE);
  assign ready_go       = !need_resp || data_ok_use || buf_valid;
  assign ms_allowin     = !ms_valid || (ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ready_go;
  assign leave          = ms_valid && ready_go && ws_allowin;
  assign load_data      = buf_valid ? buf_data : data_sram_rdata;

  mem_load_align u_align (
    .load_op   (ms_r.load_op),
    .addr      (ms_r.alu_result[1:0]),
    .rdata     (load_data),
    .rt_value  (ms_r.rt_value),
    .gr_we_in  (ms_r.gr_we),
    .result    (align_result),
    .gr_we_out (align_we)
  );

  assign gr_we_final  = ms_r.exc ? 4'b0000 : align_we;
  assign final_result = (|ms_r.load_op) ? align_result : ms_r.alu_result;

  // Repack toward write-back
  always_comb begin
    ws_bus                = '0;
    ws_bus.badvaddr       = ms_r.badvaddr;
    ws_bus.bd             = ms_r.bd;
    ws_bus.exc            = ms_r.exc;
    ws_bus.exc_type       = ms_r.exc_type;
    ws_bus.eret_flush     = ms_r.eret_flush;
    ws_bus.cp0_wen        = ms_r.cp0_wen;
    ws_bus.res_from_cp0   = ms_r.res_from_cp0;
    ws_bus.cp0_addr       = ms_r.cp0_addr;
    ws_bus.gr_we          = gr_we_final;
    ws_bus.dest           = ms_r.dest;
    ws_bus.mem_alu_result = final_result;
    ws_bus.pc             = ms_r.pc;
  end

  assign ms_to_ws_bus    = ws_bus;
  assign stall_ms_bus    = {ms_valid && (|gr_we_final), gr_we_final & {4{ms_valid}}, ms_r.dest};
  assign forward_ms_bus  = {ms_valid && ready_go, final_result};
  assign ms_exc_eret_bus = {ms_valid && ms_r.exc, ms_valid && ms_r.eret_flush};

  // Stage occupancy; flush wins over a simultaneous capture
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // Instruction payload register
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_r <= '0;
    end else if (es_to_ms_valid && ms_allowin && !flush) begin
      ms_r <= es_to_ms_bus;
    end
  end

  // Hold a response that arrived while write-back was stalled
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      buf_valid <= 1'b0;
      buf_data  <= 32'h0;
    end else if (leave) begin
      buf_valid <= 1'b0;
    end else if (ms_valid && need_resp && data_ok_use && !ws_allowin && !buf_valid) begin
      buf_valid <= 1'b1;
      buf_data  <= data_sram_rdata;
    end
  end

  // Track one outstanding response owed to a flushed load
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush && ms_valid && need_resp && !data_sram_data_ok && !buf_valid) begin
            state <= S_DISCARD;
          end
        end
        default: begin
          if (data_sram_data_ok) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads/ALU ops, stall, flush, exception.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [165:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [125:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic [9:0]   stall_ms_bus;
  logic [32:0]  forward_ms_bus;
  logic [1:0]   ms_exc_eret_bus;

  int n_chk  = 0;
  int n_pass = 0;
  logic [125:0] exp_q[$];

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .stall_ms_bus      (stall_ms_bus),
    .forward_ms_bus    (forward_ms_bus),
    .ms_exc_eret_bus   (ms_exc_eret_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [165:0] mk_es(input logic [31:0] pc, input logic [31:0] alu,
                                         input logic [31:0] rt, input logic [6:0] lop,
                                         input logic mreq, input logic ex, input logic [3:0] we);
    return {alu, 1'b0, ex, (ex ? 8'h04 : 8'h00), 3'b000, 8'h0c, we, 5'd8, lop, mreq, rt, alu, pc};
  endfunction

  function automatic logic [125:0] mk_ws(input logic [31:0] pc, input logic [31:0] alu,
                                         input logic ex, input logic [3:0] we,
                                         input logic [31:0] res);
    return {alu, 1'b0, ex, (ex ? 8'h04 : 8'h00), 3'b000, 8'h0c, we, 5'd8, res, pc};
  endfunction

  // Monitor: every transfer to WB must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_xfer: got %h expected none", ms_to_ws_bus);
      end else begin
        logic [125:0] e;
        e = exp_q.pop_front();
        check("ws_bus", 128'(ms_to_ws_bus), 128'(e));
        check("fwd_bus", 128'(forward_ms_bus), 128'({1'b1, e[63:32]}));
      end
    end
  end

  // Present one instruction and return just after the edge that captures it
  task automatic issue(input logic [165:0] b);
    bit done;
    done = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (ms_allowin) done = 1'b1;
    end
    if (done) begin
      @(posedge clk); #1;
    end else begin
      n_chk++;
      $display("FAIL issue_timeout: got ms_allowin=0 expected 1");
    end
    es_to_ms_valid = 1'b0;
  endtask

  // Load whose response arrives after wait_cyc idle cycles
  task automatic do_load(input logic [165:0] b, input int wait_cyc, input logic [31:0] rd);
    issue(b);
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      check("load_wait", 128'(ms_to_ws_valid), 128'(0));
      @(posedge clk); #1;
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_allowin", 128'(ms_allowin), 128'(1));
    check("rst_ws_valid", 128'(ms_to_ws_valid), 128'(0));
    check("rst_stall_msb", 128'(stall_ms_bus[9]), 128'(0));
    check("rst_fwd_valid", 128'(forward_ms_bus[32]), 128'(0));
    check("rst_exc_eret", 128'(ms_exc_eret_bus), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // ALU op: one-cycle latency
    exp_q.push_back(mk_ws(32'hBFC00010, 32'h1234, 1'b0, 4'hF, 32'h1234));
    issue(mk_es(32'hBFC00010, 32'h1234, 32'h0, 7'b0, 1'b0, 1'b0, 4'hF));
    @(negedge clk);
    check("alu_latency", 128'(ms_to_ws_valid), 128'(1));
    @(posedge clk); #1;

    // Byte/half loads
    exp_q.push_back(mk_ws(32'hBFC00020, 32'h1002, 1'b0, 4'hF, 32'hFFFFFF80));
    do_load(mk_es(32'hBFC00020, 32'h1002, 32'h0, 7'b1000000, 1'b1, 1'b0, 4'hF), 1, 32'h00800000);
    exp_q.push_back(mk_ws(32'hBFC00024, 32'h1002, 1'b0, 4'hF, 32'h00000080));
    do_load(mk_es(32'hBFC00024, 32'h1002, 32'h0, 7'b0100000, 1'b1, 1'b0, 4'hF), 0, 32'h00800000);
    exp_q.push_back(mk_ws(32'hBFC00028, 32'h1002, 1'b0, 4'hF, 32'hFFFF8001));
    do_load(mk_es(32'hBFC00028, 32'h1002, 32'h0, 7'b0010000, 1'b1, 1'b0, 4'hF), 2, 32'h80010000);
    exp_q.push_back(mk_ws(32'hBFC0002C, 32'h1000, 1'b0, 4'hF, 32'h0000F00D));
    do_load(mk_es(32'hBFC0002C, 32'h1000, 32'h0, 7'b0001000, 1'b1, 1'b0, 4'hF), 0, 32'h1234F00D);

    // LWL / LWR merges
    exp_q.push_back(mk_ws(32'hBFC00030, 32'h1001, 1'b0, 4'b1100, 32'hCCDD3344));
    do_load(mk_es(32'hBFC00030, 32'h1001, 32'h11223344, 7'b0000010, 1'b1, 1'b0, 4'hF), 1, 32'hAABBCCDD);
    exp_q.push_back(mk_ws(32'hBFC00034, 32'h1002, 1'b0, 4'b0011, 32'h1122AABB));
    do_load(mk_es(32'hBFC00034, 32'h1002, 32'h11223344, 7'b0000001, 1'b1, 1'b0, 4'hF), 0, 32'hAABBCCDD);

    // Response buffered across a 3-cycle write-back stall
    ws_allowin = 1'b0;
    exp_q.push_back(mk_ws(32'hBFC00040, 32'h2000, 1'b0, 4'hF, 32'hDEADBEEF));
    do_load(mk_es(32'hBFC00040, 32'h2000, 32'h0, 7'b0000100, 1'b1, 1'b0, 4'hF), 0, 32'hDEADBEEF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_buf_valid", 128'(dut.buf_valid), 128'(1));
      check("stall_ws_valid", 128'(ms_to_ws_valid), 128'(1));
      check("stall_allowin", 128'(ms_allowin), 128'(0));
      @(posedge clk); #1;
    end
    ws_allowin = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("buf_cleared", 128'(dut.buf_valid), 128'(0));
    check("stage_empty", 128'(ms_to_ws_valid), 128'(0));
    @(posedge clk); #1;

    // Flush while a load waits: its late response must be dropped
    issue(mk_es(32'hBFC00050, 32'h3000, 32'h0, 7'b0000100, 1'b1, 1'b0, 4'hF));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.push_back(mk_ws(32'hBFC00054, 32'h3004, 1'b0, 4'hF, 32'h5A5A5A5A));
    issue(mk_es(32'hBFC00054, 32'h3004, 32'h0, 7'b0000100, 1'b1, 1'b0, 4'hF));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBADBAD00;
    @(negedge clk);
    check("discard_hold", 128'(ms_to_ws_valid), 128'(0));
    @(posedge clk); #1;
    data_sram_rdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;

    // Flush coinciding with data_ok: response consumed, no discard
    ws_allowin = 1'b0;
    issue(mk_es(32'hBFC00060, 32'h4000, 32'h0, 7'b0000100, 1'b1, 1'b0, 4'hF));
    flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFF0000;
    @(posedge clk); #1;
    flush = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    ws_allowin = 1'b1;
    exp_q.push_back(mk_ws(32'hBFC00064, 32'h4004, 1'b0, 4'hF, 32'h13572468));
    do_load(mk_es(32'hBFC00064, 32'h4004, 32'h0, 7'b0000100, 1'b1, 1'b0, 4'hF), 0, 32'h13572468);

    // Flush overrides a simultaneous capture
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_es(32'hBFC00070, 32'h99, 32'h0, 7'b0, 1'b0, 1'b0, 4'hF);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; es_to_ms_valid = 1'b0;
    @(negedge clk);
    check("flush_drop_valid", 128'(ms_to_ws_valid), 128'(0));
    check("flush_drop_allowin", 128'(ms_allowin), 128'(1));
    @(posedge clk); #1;

    // Excepting load: no wait for data_ok, writes suppressed
    exp_q.push_back(mk_ws(32'hBFC00080, 32'h5000, 1'b1, 4'h0, 32'h0));
    issue(mk_es(32'hBFC00080, 32'h5000, 32'h0, 7'b0000100, 1'b1, 1'b1, 4'hF));
    @(negedge clk);
    check("exc_ready", 128'(ms_to_ws_valid), 128'(1));
    check("exc_eret_bus", 128'(ms_exc_eret_bus), 128'(2'b10));
    check("exc_stall_bus", 128'(stall_ms_bus), 128'({1'b0, 4'b0000, 5'd8}));
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    check("sb_drain", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
